xspram_param: RTL

Parametrised synchronous single-port SRAM model with a configurable read pipeline, per-byte write enables and an optional post-reset clear sweep. It serves as the general on-chip RAM block for the PicoRV32 subsystem: instruction/data RAM, peripheral buffers and any other SRAM instance. It replaces fixed-geometry single-port RAM models. Port naming and active-low enables keep existing memory controllers compatible.

---
 rtl/xspram_pkg.sv | 20 ++
 rtl/xspram_rdpipe.sv | 34 +++
 rtl/xspram_param.sv | 129 ++++++++++++
 3 files changed

// File: rtl/xspram_pkg.sv
// Shared types and helpers for the xspram single-port RAM family.
package xspram_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  // Byte-lane merge; ben is active-low, so a 1 keeps the old byte.
  function automatic logic [7:0] merge_be(input logic [7:0] old_byte,
                                          input logic [7:0] new_byte,
                                          input logic       ben);
    return ben ? old_byte : new_byte;
  endfunction

endpackage

// File: rtl/xspram_rdpipe.sv
// Read-data/valid shift register placed between the array read and the Q register.
module xspram_rdpipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             head_valid,
  input  logic [WIDTH-1:0] head_data,
  output logic             tail_valid,
  output logic [WIDTH-1:0] tail_data
);

  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  dat [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) dat[i] <= '0;
    end else begin
      vld[0] <= head_valid;
      dat[0] <= head_data;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign tail_valid = vld[STAGES-1];
  assign tail_data  = dat[STAGES-1];

endmodule

// File: rtl/xspram_param.sv
// Parametrised single-port SRAM: byte writes, RD_LAT-cycle read pipeline,
// optional zero-fill sweep after reset.
//   state    | meaning
//   ST_RESET | held while RSTn is low
//   ST_INIT  | zero-fill sweep, one word per cycle
//   ST_IDLE  | accepting accesses (RDY=1)
module xspram_param
  import xspram_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 1024,
  parameter int AW             = $clog2(DEPTH),
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               CEn,
  input  logic               WEn,
  input  logic [WIDTH/8-1:0] BEn,
  input  logic               OEn,
  input  logic [AW-1:0]      A,
  input  logic [WIDTH-1:0]   D,
  output logic [WIDTH-1:0]   Q,
  output logic               QV,
  output logic               RDY
);

  localparam int NB = WIDTH / 8;

  if ((WIDTH % 8) != 0) begin : g_bad_width
    $error("xspram_param: WIDTH must be a multiple of 8");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("xspram_param: RD_LAT must be within 1..4");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("xspram_param: DEPTH must be at least 2");
  end

  state_t          state, state_nxt;
  logic [AW-1:0]   sweep_cnt, sweep_nxt;
  logic            sweep_we;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_RESET;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep_cnt;
    sweep_we  = 1'b0;
    unique case (state)
      ST_RESET: state_nxt = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
      ST_INIT: begin
        sweep_we = 1'b1;
        if (sweep_cnt == AW'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          sweep_nxt = '0;
        end else begin
          sweep_nxt = sweep_cnt + 1'b1;
        end
      end
      ST_IDLE: state_nxt = ST_IDLE;
      default: state_nxt = ST_RESET;
    endcase
  end

  assign RDY = (state == ST_IDLE);

  logic in_range, acc, wr_acc, rd_acc;
  assign in_range = (32'(A) < DEPTH);
  assign acc      = RDY & ~CEn;
  assign wr_acc   = acc & ~WEn & in_range;
  assign rd_acc   = acc & ~OEn;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] cur_word, wr_word, rd_word;

  assign cur_word = mem[A];
  assign rd_word  = in_range ? cur_word : '0;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign wr_word[8*i +: 8] = merge_be(cur_word[8*i +: 8], D[8*i +: 8], BEn[i]);
  end

  // Array has no reset; the sweep is the only way contents get a defined value.
  always_ff @(posedge CLK) begin
    if (sweep_we)    mem[sweep_cnt] <= '0;
    else if (wr_acc) mem[A]         <= wr_word;
  end

  logic             tail_valid;
  logic [WIDTH-1:0] tail_data;

  if (RD_LAT > 1) begin : g_pipe
    xspram_rdpipe #(
      .WIDTH  (WIDTH),
      .STAGES (RD_LAT - 1)
    ) u_rdpipe (
      .clk        (CLK),
      .rst_n      (RSTn),
      .head_valid (rd_acc),
      .head_data  (rd_word),
      .tail_valid (tail_valid),
      .tail_data  (tail_data)
    );
  end else begin : g_nopipe
    assign tail_valid = rd_acc;
    assign tail_data  = rd_word;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Q  <= '0;
      QV <= 1'b0;
    end else begin
      QV <= tail_valid;
      if (tail_valid) Q <= tail_data;
    end
  end

endmodule
